hilo_muldiv_unit: RTL and testbench

- Iterative 32x32 multiply/divide engine that produces the 64-bit value loaded into the HI/LO register pair.
- Takes two 32-bit operands and produces one 64-bit result: either the product, or remainder (upper 32 bits) with quotient (lower 32 bits).
- On completion it pulses `result_valid`. That pulse drives the HI/LO register's load enable, and `result` drives its 64-bit data input.
- Sits beside the ALU in the datapath; the control unit starts it and stalls on `busy`.

---
 rtl/hilo_muldiv_unit_if.sv | 24 ++
 rtl/hilo_muldiv_unit.sv | 187 ++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between the control unit and the HI/LO multiply/divide engine.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               op;
  logic               sign_en;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] result;
  logic               result_valid;
  logic               busy;
  logic               div_by_zero;

  modport master (
    output start, op, sign_en, A, B,
    input  result, result_valid, busy, div_by_zero
  );

  modport slave (
    input  start, op, sign_en, A, B,
    output result, result_valid, busy, div_by_zero
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative 32x32 multiply / restoring divide producing the 64-bit HI/LO load value.
// MUL: result = product. DIV: result = {remainder, quotient}.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  hilo_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;

  logic [2*WIDTH-1:0] result_q, result_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               dbzo_q, dbzo_d;

  logic               a_neg, b_neg, b_zero, last;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   rem_sh, diff;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [2*WIDTH-1:0] fixed;

  assign a_neg  = bus.sign_en & bus.A[WIDTH-1];
  assign b_neg  = bus.sign_en & bus.B[WIDTH-1];
  assign a_mag  = a_neg ? -bus.A : bus.A;
  assign b_mag  = b_neg ? -bus.B : bus.B;
  assign b_zero = (bus.B == '0);
  assign last   = (cnt_q == '0);

  // Multiply step: conditionally add multiplicand to the high half, then shift right.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mb_q : {WIDTH{1'b0}})};

  // Divide step: shift next dividend bit into the partial remainder and trial-subtract.
  assign rem_sh = {rem_q, acc_q[WIDTH-1]};
  assign diff   = rem_sh - {2'b00, mb_q};

  // Sign correction applied at completion.
  assign quot_fix = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  // Final value selected for the HI/LO load.
  always_comb begin
    fixed = acc_q;
    if (dbz_q)      fixed = {acc_q[WIDTH-1:0], {WIDTH{1'b1}}};
    else if (op_q)  fixed = {rem_fix, quot_fix};
    else if (sa_q ^ sb_q) fixed = -acc_q;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = (bus.op && b_zero) ? S_FIX : S_CALC;
      S_CALC: if (last) state_d = S_FIX;
      S_FIX:  if (last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: operand capture and one iteration per CALC cycle.
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    dbz_d = dbz_q;
    mb_d  = mb_q;
    acc_d = acc_q;
    rem_d = rem_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d  = bus.op;
          sa_d  = a_neg;
          sb_d  = b_neg;
          mb_d  = b_mag;
          rem_d = '0;
          dbz_d = bus.op & b_zero;
          if (bus.op && b_zero) begin
            // Divide-by-zero parks in FIX with the counter at 1 so completion
            // lands one edge later, on the second edge after the request.
            acc_d = {{WIDTH{1'b0}}, bus.A};
            cnt_d = CW'(1);
          end else begin
            acc_d = {{WIDTH{1'b0}}, a_mag};
            cnt_d = CW'(WIDTH-1);
          end
        end
      end
      S_CALC: begin
        if (!last) cnt_d = cnt_q - CW'(1);
        if (op_q) begin
          rem_d = diff[WIDTH+1] ? rem_sh[WIDTH:0] : diff[WIDTH:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~diff[WIDTH+1]};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        if (!last) cnt_d = cnt_q - CW'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= 1'b0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      dbz_q <= 1'b0;
      mb_q  <= '0;
      acc_q <= '0;
      rem_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      dbz_q <= dbz_d;
      mb_q  <= mb_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
    end
  end

  // FSM output logic: busy on acceptance, result/valid/flag on completion.
  always_comb begin
    result_d = result_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    dbzo_d   = dbzo_q;
    case (state_q)
      S_IDLE: if (bus.start) busy_d = 1'b1;
      S_FIX: begin
        if (last) begin
          result_d = fixed;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          dbzo_d   = dbz_q;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      dbzo_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      dbzo_q   <= dbzo_d;
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.div_by_zero  = dbzo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus pushes expected results,
// a negedge monitor pops and compares whenever result_valid is seen.
module tb_hilo_muldiv_unit;
  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct {
    string       name;
    logic [63:0] res;
    logic        dbz;
    int          vcyc;
  } exp_t;

  exp_t sb[$];

  hilo_muldiv_unit_if #(.WIDTH(32)) bus();

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got result %h at cycle %0d expected no completion", bus.result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, bus.result, e.res);
        check({e.name, "_dbz"}, 64'(bus.div_by_zero), 64'(e.dbz));
        check({e.name, "_cycle"}, 64'(cyc), 64'(e.vcyc));
        check({e.name, "_busy_low"}, 64'(bus.busy), 64'd0);
      end
    end
  end

  // Caller is 1 time unit after a rising edge; the next edge is E0.
  task automatic issue(input string name, input logic op, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] res, input logic dbz);
    exp_t e;
    int   lat;
    lat = dbz ? 2 : 33;
    bus.start   = 1'b1;
    bus.op      = op;
    bus.sign_en = sgn;
    bus.A       = a;
    bus.B       = b;
    e.name = name;
    e.res  = res;
    e.dbz  = dbz;
    e.vcyc = cyc + 1 + lat;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = 32'h0BAD_F00D;
    bus.B     = 32'h0000_0003;
    check({name, "_busy_after_E0"}, 64'(bus.busy), 64'd1);
  endtask

  // Returns 1 time unit after the edge that raises result_valid.
  task automatic wait_valid(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.result_valid === 1'b1) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no result_valid expected one within 60 cycles", name);
    end
  endtask

  task automatic run(input string name, input logic op, input logic sgn,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] res, input logic dbz);
    issue(name, op, sgn, a, b, res, dbz);
    wait_valid(name);
    @(posedge clk); #1;
  endtask

  initial begin
    cyc = 0;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.sign_en = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", bus.result, 64'd0);
    check("reset_valid", 64'(bus.result_valid), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_dbz", 64'(bus.div_by_zero), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run("umul_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run("smul_neg", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run("umul_nosign", 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7,      64'h0000_0006_FFFF_FFEB, 1'b0);
    run("sdiv_negA", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run("sdiv_negB", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE,        64'h0000_0001_FFFF_FFFD, 1'b0);
    run("udiv_100_7", 1'b1, 1'b0, 32'd100, 32'd7,             64'h0000_0002_0000_000E, 1'b0);
    run("sdiv_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
    run("div_zero", 1'b1, 1'b0, 32'h1234_5678, 32'd0,         64'h1234_5678_FFFF_FFFF, 1'b1);
    run("udiv_after_dbz", 1'b1, 1'b0, 32'd9, 32'd3,           64'h0000_0000_0000_0003, 1'b0);

    // Start pulses while busy must not disturb the running multiply.
    issue("mul_ignore", 1'b0, 1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_valid("mul_ignore");

    // New request in the completion cycle is accepted at that edge.
    @(posedge clk); #1;
    issue("b2b_first", 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0);
    wait_valid("b2b_first");
    issue("b2b_second", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF, 1'b0);
    wait_valid("b2b_second");
    @(posedge clk); #1;

    run("sdiv_zero", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 1'b1);

    // Reset mid-multiply: outputs clear at once and no completion follows.
    issue("mul_reset", 1'b0, 1'b0, 32'd11, 32'd13, 64'd143, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_result", bus.result, 64'd0);
    check("midreset_valid", 64'(bus.result_valid), 64'd0);
    check("midreset_busy", 64'(bus.busy), 64'd0);
    check("midreset_dbz", 64'(bus.div_by_zero), 64'd0);
    void'(sb.pop_back());
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("postreset_busy", 64'(bus.busy), 64'd0);
    check("postreset_result", bus.result, 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
